// File: rtl/product_drain.sv
// product_drain: consumer of the product-memory block-read burst.
// Requests a block, captures the beats through a one-entry hold register so the
// final word of each block can be tagged, buffers them in a FIFO and replays them
// on a valid/ready stream with out_last marking each block's final word.
`timescale 1ns/1ps

module product_drain #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned LOGDEPTH    = 6,
    parameter int unsigned BLOCK_WORDS = 64,
    parameter int unsigned GAP_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                drain_en,
    output logic                EN_blockRead,
    input  logic                VALID_memVal,
    input  logic [WIDTH-1:0]    memVal_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    output logic                block_done,
    output logic [LOGDEPTH:0]   block_words,
    output logic                ovf_err,
    input  logic                clr_err
);

    localparam int unsigned DEPTH = 1 << LOGDEPTH;
    localparam int unsigned CNT_W = LOGDEPTH + 1;
    localparam int unsigned ROOM_W = CNT_W + 1;
    localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // State and storage
    logic [1:0]          r_state;
    logic [WIDTH:0]      r_mem [DEPTH];
    logic [LOGDEPTH-1:0] r_wr_ptr;
    logic [LOGDEPTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_hold_vld;
    logic [WIDTH-1:0]    r_hold_data;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_en;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_last;
    logic                r_block_done;
    logic [CNT_W-1:0]    r_block_words;
    logic                r_ovf;

    // Next-state / control
    logic [1:0]          w_state_nxt;
    logic                w_capture;
    logic                w_push;
    logic                w_push_last;
    logic                w_drop;
    logic [CNT_W-1:0]    w_beat_nxt;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic                w_room;
    logic [ROOM_W-1:0]   w_used;

    // FIFO bookkeeping
    logic                w_pop;
    logic                w_full;
    logic                w_push_ok;
    logic [LOGDEPTH-1:0] w_wr_nxt;
    logic [LOGDEPTH-1:0] w_rd_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [WIDTH:0]      w_head_nxt;

    assign EN_blockRead = r_en;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign block_done   = r_block_done;
    assign block_words  = r_block_words;
    assign ovf_err      = r_ovf;

    // Room for a whole block counts the hold register as an occupied slot
    assign w_used = ROOM_W'(r_count) + ROOM_W'(r_hold_vld);
    assign w_room = (w_used + ROOM_W'(BLOCK_WORDS)) <= ROOM_W'(DEPTH);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state, beat/gap counting and hold-register push decisions
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_drop      = 1'b0;
        w_beat_nxt  = r_beat_cnt;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                w_drop = VALID_memVal;
                if (drain_en && w_room) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (VALID_memVal) begin
                    w_capture   = 1'b1;
                    w_beat_nxt  = CNT_W'(1);
                    w_gap_nxt   = '0;
                    w_state_nxt = S_RECV;
                end else if (!drain_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RECV: begin
                if (VALID_memVal) begin
                    w_capture = 1'b1;
                    w_gap_nxt = '0;
                    if (r_beat_cnt < CNT_W'(BLOCK_WORDS)) begin
                        w_beat_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
                if ((w_beat_nxt >= CNT_W'(BLOCK_WORDS)) || (w_gap_nxt >= GAP_W'(GAP_TIMEOUT))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_drop      = VALID_memVal;
                w_push      = r_hold_vld;
                w_push_last = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_capture && r_hold_vld) begin
            w_push      = 1'b1;
            w_push_last = 1'b0;
        end
    end

    // FIFO pointer/count arithmetic and the head word visible after this edge
    always_comb begin
        w_pop       = r_out_valid & out_ready;
        w_full      = (r_count == CNT_W'(DEPTH));
        w_push_ok   = w_push & (~w_full | w_pop);
        w_wr_nxt    = r_wr_ptr + LOGDEPTH'(w_push_ok);
        w_rd_nxt    = r_rd_ptr + LOGDEPTH'(w_pop);
        w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
        if (w_push_ok && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = {w_push_last, r_hold_data};
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_push_last, r_hold_data};
        end
    end

    // Datapath registers, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_hold_vld    <= 1'b0;
            r_hold_data   <= '0;
            r_beat_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_en          <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_block_done  <= 1'b0;
            r_block_words <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_gap_cnt  <= w_gap_nxt;
            if (w_capture) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= memVal_data;
            end else if (r_state == S_DONE) begin
                r_hold_vld <= 1'b0;
            end
            r_en         <= (w_state_nxt == S_REQ);
            r_block_done <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                r_block_words <= w_beat_nxt;
            end
            r_out_valid <= (w_count_nxt != '0);
            r_out_data  <= (w_count_nxt != '0) ? w_head_nxt[WIDTH-1:0] : '0;
            r_out_last  <= (w_count_nxt != '0) ? w_head_nxt[WIDTH] : 1'b0;
            if (clr_err) begin
                r_ovf <= 1'b0;
            end else if (w_drop || (w_push && !w_push_ok)) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_product_drain.sv
// Scoreboard bench for product_drain: the driver queues expected words and block
// sizes as it issues beats; a monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps

module tb_product_drain;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned LOGDEPTH = 6;
    localparam int unsigned BW       = 64;
    localparam int unsigned GT       = 4;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } word_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                drain_en = 1'b0;
    logic                EN_blockRead;
    logic                VALID_memVal = 1'b0;
    logic [WIDTH-1:0]    memVal_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [WIDTH-1:0]    out_data;
    logic                out_last;
    logic                block_done;
    logic [LOGDEPTH:0]   block_words;
    logic                ovf_err;
    logic                clr_err = 1'b0;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_done = 0;
    int    n_blocks = 0;
    int    ready_mode = 0;
    word_t exp_q[$];
    int    exp_blk_q[$];

    product_drain #(
        .WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH), .BLOCK_WORDS(BW), .GAP_TIMEOUT(GT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drain_en(drain_en), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .block_done(block_done), .block_words(block_words), .ovf_err(ovf_err),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sink readiness, changed just after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares delivered words, stall stability and finished block sizes
    initial begin
        word_t e;
        word_t prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_stable", {31'd0, out_valid, out_last, out_data}, {31'd0, 1'b1, prev});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got 0x%0h last=%0b, expected no word", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", {31'd0, out_last, out_data}, {31'd0, e});
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev = {out_last, out_data};
                if (block_done) begin
                    n_done++;
                    if (exp_blk_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_block_done: got words=%0d, expected no block", block_words);
                    end else begin
                        check("block_words", 64'(block_words), 64'(exp_blk_q.pop_front()));
                    end
                end
            end
        end
    end

    // Wait (bounded) for the block request
    task automatic wait_en();
        int t;
        t = 0;
        while (EN_blockRead !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        check("en_request", 64'(EN_blockRead), 64'd1);
    endtask

    // Drive n beats (optionally gapped); stop_after < n truncates for the reset case
    task automatic drive_beats(input int n, input bit gaps, input bit seq, input int stop_after);
        logic [WIDTH-1:0] d;
        for (int i = 0; i < stop_after; i++) begin
            d = seq ? WIDTH'(i) : WIDTH'($urandom);
            VALID_memVal = 1'b1;
            memVal_data  = d;
            exp_q.push_back({(i == n - 1), d});
            tick();
            VALID_memVal = 1'b0;
            if (i == 0) check("en_drop", 64'(EN_blockRead), 64'd0);
            if (gaps && i < n - 1) repeat ($urandom_range(0, GT - 1)) tick();
        end
    endtask

    // One complete block with exact block_done timing
    task automatic run_block(input int n, input bit gaps, input bit seq);
        wait_en();
        exp_blk_q.push_back(n);
        n_blocks++;
        drive_beats(n, gaps, seq, n);
        if (n >= int'(BW)) begin
            check("done_full", 64'(block_done), 64'd1);
        end else begin
            repeat (GT - 1) tick();
            check("done_early", 64'(block_done), 64'd0);
            tick();
            check("done_gap", 64'(block_done), 64'd1);
        end
        tick();
        check("done_pulse", 64'(block_done), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {22'd0, EN_blockRead, out_valid, out_data, out_last, block_done, block_words, ovf_err},
              64'd0);
    endtask

    initial begin
        int t;
        repeat (3) tick();
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        drain_en = 1'b1;
        ready_mode = 0;

        // Full block 0..63, then a short block of 63
        run_block(64, 1'b0, 1'b1);
        run_block(63, 1'b0, 1'b0);

        // Backpressure through a full block
        ready_mode = 2;
        run_block(64, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("no_req_full", 64'(EN_blockRead), 64'd0);
        end
        check("ovf_after_bp", 64'(ovf_err), 64'd0);
        ready_mode = 1;
        wait_en();
        check("empty_at_req", 64'(out_valid), 64'd0);

        // Gapped short block
        run_block(20, 1'b1, 1'b0);

        // Reset in the middle of a block
        ready_mode = 0;
        wait_en();
        drive_beats(64, 1'b0, 1'b0, 10);
        rst_n = 1'b0;
        #1;
        check_all_zero("midblock_reset");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_after_reset", 64'(out_valid), 64'd0);
        end
        run_block(30, 1'b1, 1'b0);

        // Spurious beats while idle and error clearing
        drain_en = 1'b0;
        repeat (80) tick();
        check("idle_no_req", 64'(EN_blockRead), 64'd0);
        VALID_memVal = 1'b1;
        tick();
        VALID_memVal = 1'b0;
        check("ovf_set", 64'(ovf_err), 64'd1);
        repeat (3) tick();
        check("ovf_sticky", 64'(ovf_err), 64'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clear", 64'(ovf_err), 64'd0);
        VALID_memVal = 1'b1;
        tick();
        check("ovf_reset_again", 64'(ovf_err), 64'd1);
        clr_err = 1'b1;
        tick();
        VALID_memVal = 1'b0;
        clr_err = 1'b0;
        check("ovf_clr_wins", 64'(ovf_err), 64'd0);

        // Randomised blocks under a random sink
        drain_en = 1'b1;
        ready_mode = 1;
        for (int b = 0; b < 5; b++) begin
            run_block($urandom_range(1, BW), 1'($urandom_range(0, 1)), 1'b0);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            tick();
            t++;
        end
        check("drained", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
        check("blocks_done", 64'(n_done), 64'(n_blocks));
        check("ovf_final", 64'(ovf_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
